// File: rtl/sonar_ping_ctrl.sv
// Sonar ping sequencer: TX burst, receiver blanking, then a debounced echo listen window.
// Reports time-of-flight with a done pulse, a held result and a sticky IRQ.
module sonar_ping_ctrl #(
    parameter int CNT_W = 16,
    parameter int DEB   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] tx_len,
    input  logic [CNT_W-1:0] blank_len,
    input  logic [CNT_W-1:0] listen_len,
    input  logic             echo_i,
    input  logic             irq_clr,
    output logic             tx_en_o,
    output logic             rx_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             hit_o,
    output logic [CNT_W-1:0] tof_o,
    output logic             irq_o
);
    // state  | meaning
    // IDLE   | waiting for start
    // TX     | transmit burst, tx_len cycles
    // BLANK  | receiver enabled, echo ignored, blank_len cycles
    // LISTEN | debounced echo search, listen_len cycles max
    // DONE   | one-cycle result pulse
    typedef enum logic [2:0] {S_IDLE, S_TX, S_BLANK, S_LISTEN, S_DONE} state_t;

    localparam int DEB_W = $clog2(DEB + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB);

    state_t           state, state_nx;
    logic [CNT_W-1:0] tx_s, blank_s, listen_s;
    logic [CNT_W-1:0] cnt, cnt_ld;
    logic             load_cnt;
    logic [CNT_W-1:0] lcnt;
    logic [DEB_W-1:0] deb;
    logic             hit_now;
    logic             res_hit;
    logic [CNT_W-1:0] res_tof;

    assign hit_now = echo_i && (deb == DEB_MAX - DEB_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_cnt = 1'b0;
        cnt_ld   = '0;
        res_hit  = 1'b0;
        res_tof  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (tx_len != '0) begin
                        state_nx = S_TX;
                        load_cnt = 1'b1;
                        cnt_ld   = tx_len;
                    end else if (blank_len != '0) begin
                        state_nx = S_BLANK;
                        load_cnt = 1'b1;
                        cnt_ld   = blank_len;
                    end else if (listen_len != '0) begin
                        state_nx = S_LISTEN;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_TX: begin
                if (cnt == CNT_W'(1)) begin
                    if (blank_s != '0) begin
                        state_nx = S_BLANK;
                        load_cnt = 1'b1;
                        cnt_ld   = blank_s;
                    end else if (listen_s != '0) begin
                        state_nx = S_LISTEN;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_BLANK: begin
                if (cnt == CNT_W'(1))
                    state_nx = (listen_s != '0) ? S_LISTEN : S_DONE;
            end
            S_LISTEN: begin
                // hit is checked first so it wins over a same-cycle timeout
                if (hit_now) begin
                    state_nx = S_DONE;
                    res_hit  = 1'b1;
                    res_tof  = lcnt - CNT_W'(DEB - 1);
                end else if (lcnt == listen_s - CNT_W'(1)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_comb begin
        tx_en_o = 1'b0;
        rx_en_o = 1'b0;
        busy_o  = 1'b1;
        done_o  = 1'b0;
        case (state)
            S_IDLE:   busy_o  = 1'b0;
            S_TX:     tx_en_o = 1'b1;
            S_BLANK:  rx_en_o = 1'b1;
            S_LISTEN: rx_en_o = 1'b1;
            S_DONE:   done_o  = 1'b1;
            default:  busy_o  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_s     <= '0;
            blank_s  <= '0;
            listen_s <= '0;
            cnt      <= '0;
            lcnt     <= '0;
            deb      <= '0;
            hit_o    <= 1'b0;
            tof_o    <= '0;
            irq_o    <= 1'b0;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                tx_s     <= tx_len;
                blank_s  <= blank_len;
                listen_s <= listen_len;
            end
            if (load_cnt)       cnt <= cnt_ld;
            else if (cnt != '0) cnt <= cnt - CNT_W'(1);
            if (state_nx == S_LISTEN && state != S_LISTEN) begin
                lcnt <= '0;
                deb  <= '0;
            end else if (state == S_LISTEN) begin
                lcnt <= lcnt + CNT_W'(1);
                if (!echo_i)             deb <= '0;
                else if (deb != DEB_MAX) deb <= deb + DEB_W'(1);
            end
            // DONE is only ever entered from a non-DONE state, so this fires once per result
            if (state_nx == S_DONE) begin
                hit_o <= res_hit;
                tof_o <= res_tof;
            end
            if (state == S_DONE) irq_o <= 1'b1;
            else if (irq_clr)    irq_o <= 1'b0;
        end
    end
endmodule
